// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control/status bundle between the multi-cycle controller and
// the shared datapath with its instruction and data memories.
//   master (controller): takes opcode, funct, zero, imem_ready, dmem_ready;
//                        drives every datapath select/enable, the memory
//                        requests and the illegal/bus_err event pulses.
//   slave  (datapath side): the mirror image.
// Optional macro CTRL_PERF_CNT_EN adds the 32-bit instr_retired output.
interface mc_ctrl_if;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        imem_ready;
   logic        dmem_ready;
   logic        imem_req;
   logic        dmem_req;
   logic        Mem_Write;
   logic        IR_Write;
   logic        PC_Write;
   logic [1:0]  PC_Src;
   logic [1:0]  Ext_Op;
   logic [1:0]  ALU_Op;
   logic        ALU_SrcB;
   logic        Reg_Write;
   logic        Reg_Dst;
   logic        WD_Sel;
   logic        illegal;
   logic        bus_err;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] instr_retired;
`endif

   modport master (
`ifdef CTRL_PERF_CNT_EN
      output instr_retired,
`endif
      input  opcode, funct, zero, imem_ready, dmem_ready,
      output imem_req, dmem_req, Mem_Write, IR_Write, PC_Write, PC_Src,
             Ext_Op, ALU_Op, ALU_SrcB, Reg_Write, Reg_Dst, WD_Sel,
             illegal, bus_err
   );

   modport slave (
`ifdef CTRL_PERF_CNT_EN
      input  instr_retired,
`endif
      output opcode, funct, zero, imem_ready, dmem_ready,
      input  imem_req, dmem_req, Mem_Write, IR_Write, PC_Write, PC_Src,
             Ext_Op, ALU_Op, ALU_SrcB, Reg_Write, Reg_Dst, WD_Sel,
             illegal, bus_err
   );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the Lite MIPS32 CPU. Steps the shared
// datapath through FETCH/DECODE/EXE/MEM/WB and handshakes with instruction
// and data memories that may insert wait states.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mc_ctrl_if.master: decode inputs, ready handshakes, datapath
//          selects/enables (all combinational), illegal and bus_err pulses
// Parameter FETCH_TIMEOUT: wait cycles in FETCH before bus_err pulses
// (0 disables the timeout).
// Optional macro CTRL_PERF_CNT_EN: adds bus.instr_retired, a wrapping count
// of instructions that completed (illegal instructions are not counted).
module mc_ctrl #(
   parameter int unsigned FETCH_TIMEOUT = 0
) (
   input logic        clk,
   input logic        rst,
   mc_ctrl_if.master  bus
);
   localparam int unsigned CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (FETCH_TIMEOUT > 0) ? CNT_W'(FETCH_TIMEOUT - 1) : '0;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_rtype, supported, fetch_ready;

   assign is_rtype  = (bus.opcode == OP_R);
   assign supported = (is_rtype && (bus.funct == FN_ADDU || bus.funct == FN_SUBU)) ||
                      (bus.opcode inside {OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW,
                                          OP_BEQ, OP_J});
   // While rst is high the state is already FETCH; masking ready here keeps
   // IR_Write/PC_Write low for the whole reset window.
   assign fetch_ready = bus.imem_ready & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = S_FETCH;
      cnt_d         = '0;
      bus.imem_req  = 1'b0;
      bus.dmem_req  = 1'b0;
      bus.Mem_Write = 1'b0;
      bus.IR_Write  = 1'b0;
      bus.PC_Write  = 1'b0;
      bus.PC_Src    = 2'b00;
      bus.ALU_Op    = 2'b00;
      bus.ALU_SrcB  = 1'b0;
      bus.Reg_Write = 1'b0;
      bus.Reg_Dst   = 1'b0;
      bus.WD_Sel    = 1'b0;
      bus.illegal   = 1'b0;
      bus.bus_err   = 1'b0;

      // Immediate extender mode follows the opcode in every state.
      case (bus.opcode)
         OP_ADDIU, OP_LW, OP_SW, OP_BEQ: bus.Ext_Op = 2'b01;
         OP_LUI:                         bus.Ext_Op = 2'b10;
         default:                        bus.Ext_Op = 2'b00;
      endcase

      case (state_q)
         S_FETCH: begin
            bus.imem_req = 1'b1;
            state_d      = S_FETCH;
            if (fetch_ready) begin
               bus.IR_Write = 1'b1;
               bus.PC_Write = 1'b1;
               state_d      = S_DECODE;
            end else if (FETCH_TIMEOUT > 0) begin
               // cnt_q counts completed wait cycles; the wait that brings the
               // total to FETCH_TIMEOUT raises bus_err and restarts the count.
               if (cnt_q == CNT_LAST) begin
                  bus.bus_err = ~rst;
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_DECODE: begin
            if (bus.opcode == OP_J) begin
               bus.PC_Write = 1'b1;
               bus.PC_Src   = 2'b10;
            end else if (!supported) begin
               bus.illegal = 1'b1;
            end else begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            if (is_rtype) begin
               bus.ALU_Op = (bus.funct == FN_SUBU) ? 2'b01 : 2'b00;
               state_d    = S_WB;
            end else if (bus.opcode == OP_BEQ) begin
               bus.ALU_Op   = 2'b01;
               bus.PC_Src   = 2'b01;
               bus.PC_Write = bus.zero;
            end else begin
               // lui relies on the datapath presenting 0 on port A.
               bus.ALU_SrcB = 1'b1;
               bus.ALU_Op   = (bus.opcode == OP_ORI) ? 2'b10 : 2'b00;
               state_d      = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            bus.dmem_req  = 1'b1;
            bus.Mem_Write = (bus.opcode == OP_SW);
            if (bus.dmem_ready)
               state_d = (bus.opcode == OP_SW) ? S_FETCH : S_WB;
            else
               state_d = S_MEM;
         end
         S_WB: begin
            bus.Reg_Write = 1'b1;
            bus.Reg_Dst   = is_rtype;
            bus.WD_Sel    = (bus.opcode == OP_LW);
         end
         default: state_d = S_FETCH;
      endcase
   end

`ifdef CTRL_PERF_CNT_EN
   logic retire;
   assign retire = (state_q inside {S_DECODE, S_EXE, S_MEM, S_WB}) &&
                   (state_d == S_FETCH) && !bus.illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bus.instr_retired <= '0;
      else if (retire)
         bus.instr_retired <= bus.instr_retired + 32'd1;
   end
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl (FETCH_TIMEOUT=4). Each cycle
// drives the decode/handshake inputs, queues the expected output vector and
// compares it against the DUT outputs at the falling edge.
module tb_mc_ctrl;
   localparam logic [5:0] OP_R = 6'h00, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                          OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04,
                          OP_J = 6'h02, OP_BAD = 6'h3F;
   localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        ir;
      logic        dr;
      logic [16:0] ex;
   } cyc_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   exp_ret = 0;
   logic [16:0] sb[$];
   logic [16:0] obs;

   mc_ctrl_if bus ();
   mc_ctrl #(.FETCH_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus.master));

   always #5 clk = ~clk;

   assign obs = {bus.imem_req, bus.dmem_req, bus.Mem_Write, bus.IR_Write,
                 bus.PC_Write, bus.PC_Src, bus.Ext_Op, bus.ALU_Op, bus.ALU_SrcB,
                 bus.Reg_Write, bus.Reg_Dst, bus.WD_Sel, bus.illegal, bus.bus_err};

   // Expected output vector, fields in the same order as obs.
   function automatic logic [16:0] ev(input logic imr, dmr, mw, irw, pcw,
                                      input logic [1:0] pcs, ext, alu,
                                      input logic srcb, rw, rd, wd, ill, be);
      return {imr, dmr, mw, irw, pcw, pcs, ext, alu, srcb, rw, rd, wd, ill, be};
   endfunction

   function automatic cyc_t mk(input logic [5:0] op, fn, input logic z, ir, dr,
                               input logic [16:0] ex);
      cyc_t c;
      c.op = op; c.fn = fn; c.z = z; c.ir = ir; c.dr = dr; c.ex = ex;
      return c;
   endfunction

   task automatic apply(input cyc_t c);
      bus.opcode     = c.op;
      bus.funct      = c.fn;
      bus.zero       = c.z;
      bus.imem_ready = c.ir;
      bus.dmem_ready = c.dr;
      sb.push_back(c.ex);
   endtask

   task automatic test_reset();
      logic [16:0] e;
      apply(mk(OP_R, 6'h00, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
      repeat (2) @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_idle: got %b, expected %b", obs, e); end
      // imem_ready during reset must not load IR or PC.
      apply(mk(OP_R, 6'h00, 0, 1, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
      #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_ready: got %b, expected %b", obs, e); end
`ifdef CTRL_PERF_CNT_EN
      checks++;
      if (bus.instr_retired !== 32'd0) begin
         errors++; $display("FAIL reset_retired: got %0d, expected 0", bus.instr_retired);
      end
`endif
      bus.imem_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 10; i++) begin
         logic [16:0] e;
         apply(mk(OP_R, 6'h00, 0, 0, 0,
                  ev(1,0,0,0,0,0,0,0,0,0,0,0,0, (i == 3 || i == 7))));
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL timeout[%0d]: got %b, expected %b", i, obs, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alu_ops();
      cyc_t seq[$];
      // addu: FETCH, DECODE, EXE, WB, FETCH
      seq.push_back(mk(OP_R, FN_ADDU, 0, 1, 0, ev(1,0,0,1,1,0,0,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_R, FN_ADDU, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_R, FN_ADDU, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_R, FN_ADDU, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,1,1,0,0,0)));
      seq.push_back(mk(OP_R, FN_ADDU, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
      // subu
      seq.push_back(mk(OP_R, FN_SUBU, 0, 1, 0, ev(1,0,0,1,1,0,0,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_R, FN_SUBU, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_R, FN_SUBU, 0, 0, 0, ev(0,0,0,0,0,0,0,1,0,0,0,0,0,0)));
      seq.push_back(mk(OP_R, FN_SUBU, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,1,1,0,0,0)));
      seq.push_back(mk(OP_R, FN_SUBU, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
      // lui: Ext_Op=10 everywhere
      seq.push_back(mk(OP_LUI, 6'h00, 0, 1, 0, ev(1,0,0,1,1,0,2,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_LUI, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,2,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_LUI, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,2,0,1,0,0,0,0,0)));
      seq.push_back(mk(OP_LUI, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,2,0,0,1,0,0,0,0)));
      seq.push_back(mk(OP_LUI, 6'h00, 0, 0, 0, ev(1,0,0,0,0,0,2,0,0,0,0,0,0,0)));
      // ori: Ext_Op=00, ALU_Op=10
      seq.push_back(mk(OP_ORI, 6'h00, 0, 1, 0, ev(1,0,0,1,1,0,0,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_ORI, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_ORI, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,0,2,1,0,0,0,0,0)));
      seq.push_back(mk(OP_ORI, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,1,0,0,0,0)));
      seq.push_back(mk(OP_ORI, 6'h00, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
      for (int i = 0; i < seq.size(); i++) begin
         logic [16:0] e;
         apply(seq[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL alu_ops[%0d]: got %b, expected %b", i, obs, e); end
         @(posedge clk); #1;
      end
      exp_ret += 4;
   endtask

   task automatic test_mem_stall();
      cyc_t seq[$];
      // lw with three dmem wait cycles
      seq.push_back(mk(OP_LW, 6'h00, 0, 1, 0, ev(1,0,0,1,1,0,1,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_LW, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,1,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_LW, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,1,0,1,0,0,0,0,0)));
      for (int k = 0; k < 4; k++)
         seq.push_back(mk(OP_LW, 6'h00, 0, 0, (k == 3), ev(0,1,0,0,0,0,1,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_LW, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,1,0,0,1,0,1,0,0)));
      seq.push_back(mk(OP_LW, 6'h00, 0, 0, 0, ev(1,0,0,0,0,0,1,0,0,0,0,0,0,0)));
      // sw with the same stall, no WB afterwards
      seq.push_back(mk(OP_SW, 6'h00, 0, 1, 0, ev(1,0,0,1,1,0,1,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_SW, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,1,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_SW, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,1,0,1,0,0,0,0,0)));
      for (int k = 0; k < 4; k++)
         seq.push_back(mk(OP_SW, 6'h00, 0, 0, (k == 3), ev(0,1,1,0,0,0,1,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_SW, 6'h00, 0, 0, 0, ev(1,0,0,0,0,0,1,0,0,0,0,0,0,0)));
      for (int i = 0; i < seq.size(); i++) begin
         logic [16:0] e;
         apply(seq[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL mem_stall[%0d]: got %b, expected %b", i, obs, e); end
         @(posedge clk); #1;
      end
      exp_ret += 2;
   endtask

   task automatic test_branch_jump();
      cyc_t seq[$];
      // beq taken
      seq.push_back(mk(OP_BEQ, 6'h00, 1, 1, 0, ev(1,0,0,1,1,0,1,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_BEQ, 6'h00, 1, 0, 0, ev(0,0,0,0,0,0,1,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_BEQ, 6'h00, 1, 0, 0, ev(0,0,0,0,1,1,1,1,0,0,0,0,0,0)));
      seq.push_back(mk(OP_BEQ, 6'h00, 1, 0, 0, ev(1,0,0,0,0,0,1,0,0,0,0,0,0,0)));
      // beq not taken
      seq.push_back(mk(OP_BEQ, 6'h00, 0, 1, 0, ev(1,0,0,1,1,0,1,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_BEQ, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,1,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_BEQ, 6'h00, 0, 0, 0, ev(0,0,0,0,0,1,1,1,0,0,0,0,0,0)));
      seq.push_back(mk(OP_BEQ, 6'h00, 0, 0, 0, ev(1,0,0,0,0,0,1,0,0,0,0,0,0,0)));
      // j
      seq.push_back(mk(OP_J, 6'h00, 0, 1, 0, ev(1,0,0,1,1,0,0,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_J, 6'h00, 0, 0, 0, ev(0,0,0,0,1,2,0,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_J, 6'h00, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
      for (int i = 0; i < seq.size(); i++) begin
         logic [16:0] e;
         apply(seq[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL branch_jump[%0d]: got %b, expected %b", i, obs, e); end
         @(posedge clk); #1;
      end
      exp_ret += 3;
   endtask

   task automatic test_illegal();
      cyc_t seq[$];
      seq.push_back(mk(OP_BAD, 6'h00, 0, 1, 0, ev(1,0,0,1,1,0,0,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_BAD, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0,1,0)));
      seq.push_back(mk(OP_BAD, 6'h00, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
      // R-type with an unsupported funct
      seq.push_back(mk(OP_R, 6'h20, 0, 1, 0, ev(1,0,0,1,1,0,0,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_R, 6'h20, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0,1,0)));
      seq.push_back(mk(OP_R, 6'h20, 0, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
      for (int i = 0; i < seq.size(); i++) begin
         logic [16:0] e;
         apply(seq[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL illegal[%0d]: got %b, expected %b", i, obs, e); end
         @(posedge clk); #1;
      end
`ifdef CTRL_PERF_CNT_EN
      @(negedge clk);
      checks++;
      if (bus.instr_retired !== 32'(exp_ret)) begin
         errors++; $display("FAIL retired: got %0d, expected %0d", bus.instr_retired, exp_ret);
      end
      @(posedge clk); #1;
`endif
   endtask

   task automatic test_reset_in_mem();
      cyc_t seq[$];
      logic [16:0] e;
      seq.push_back(mk(OP_SW, 6'h00, 0, 1, 0, ev(1,0,0,1,1,0,1,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_SW, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,1,0,0,0,0,0,0,0)));
      seq.push_back(mk(OP_SW, 6'h00, 0, 0, 0, ev(0,0,0,0,0,0,1,0,1,0,0,0,0,0)));
      seq.push_back(mk(OP_SW, 6'h00, 0, 0, 0, ev(0,1,1,0,0,0,1,0,0,0,0,0,0,0)));
      for (int i = 0; i < seq.size(); i++) begin
         apply(seq[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL rst_mem[%0d]: got %b, expected %b", i, obs, e); end
         if (i < seq.size() - 1) begin @(posedge clk); #1; end
      end
      // Mid-cycle reset while in MEM: back to FETCH immediately, no writes.
      #1 rst = 1'b1;
      apply(mk(OP_SW, 6'h00, 0, 1, 0, ev(1,0,0,0,0,0,1,0,0,0,0,0,0,0)));
      #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rst_mem_async: got %b, expected %b", obs, e); end
      @(posedge clk); #1;
      rst = 1'b0;
      apply(mk(OP_SW, 6'h00, 0, 1, 0, ev(1,0,0,1,1,0,1,0,0,0,0,0,0,0)));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rst_mem_release: got %b, expected %b", obs, e); end
   endtask

   initial begin
      bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0;
      bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
      test_reset();
      test_timeout();
      test_alu_ops();
      test_mem_stall();
      test_branch_jump();
      test_illegal();
      test_reset_in_mem();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end
endmodule
